wbi_cmd_arb: RTL and testbench
==============================

WBI_CMD_ARB -- requirements
Module: wbi_cmd_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- AW, 32, address width
- BW, 4, byte-enable width
- BL, 10, burst-count width
- DW, 32, data width
- OD, 4, outstanding-command depth, power of 2
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- mclk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- m<i>_cmd_wval_i / m<i>_cmd_wrdy_o (i=0,1), in/out, 1, requester command valid/ready
- m<i>_cmd_adr_i, in, AW, address
- m<i>_cmd_we_i, in, 1, write
- m<i>_cmd_dat_i, in, DW, write data
- m<i>_cmd_sel_i, in, BW, byte enable
- m<i>_cmd_tid_i, in, 4, transaction id
- m<i>_cmd_bl_i, in, BL, burst count
- m<i>_res_rrdy_i / m<i>_res_rval_o, in/out, 1, requester response ready/valid
- m<i>_res_dat_o, out, DW, read data
- m<i>_res_ack_o, m<i>_res_lack_o, m<i>_res_err_o, out, 1 each, ack / last beat / error
- m<i>_res_tid_o, out, 4, response id
- s_cmd_wval_o, s_cmd_wrdy_i plus s_cmd_adr_o/we_o/dat_o/sel_o/tid_o/bl_o, out/in, as m<i>, shared command port toward the stagging chain
- s_res_rval_i, s_res_rrdy_o plus s_res_dat_i/ack_i/lack_i/err_i/tid_i, in/out, as m<i>, shared response port

Function
REQ-003 Command transfer SHALL occur on a cycle with wval=1 and wrdy=1; response transfer on rval=1 and rrdy=1.
REQ-004 Command path SHALL be combinational from the granted master: s_cmd_* = m<g>_cmd_*; s_cmd_wval_o = m<g>_cmd_wval_i & ~blk; m<g>_cmd_wrdy_o = s_cmd_wrdy_i & ~blk; the non-granted wrdy SHALL be 0.
REQ-005 blk SHALL be 1 when the order FIFO holds OD entries and the current beat is a first beat; continuation write beats SHALL never be blocked.
REQ-006 When unlocked, g SHALL be chosen round-robin among masters with wval=1: sole requester wins; if both request, the master not granted last wins; after reset m0 has priority.
REQ-007 The last-winner pointer SHALL update only on a transferred first beat.
REQ-008 First beat with we=1 and bl>1 SHALL set lock and load beat counter = bl-1; each later transferred beat decrements it; lock clears on the beat that brings it to 0; g SHALL remain fixed while locked.
REQ-009 Reads and bl<=1 writes SHALL be single-beat commands and never lock; bl=0 SHALL be treated as 1.
REQ-010 Each transferred first beat SHALL push the winner id into an OD-deep in-order FIFO; continuation beats SHALL NOT push.
REQ-011 Response path SHALL route to FIFO head h: m<h>_res_* = s_res_*, m<h>_res_rval_o = s_res_rval_i & ~empty, s_res_rrdy_o = m<h>_res_rrdy_i & ~empty; the other master's rval SHALL be 0.
REQ-012 A transferred response beat with lack=1 SHALL pop the FIFO; other beats SHALL NOT pop.
REQ-013 Push and pop in the same cycle SHALL leave occupancy unchanged; push is blocked when full even if a pop occurs that cycle.
REQ-014 FIFO empty with s_res_rval_i=1 SHALL stall (s_res_rrdy_o=0) with no state change.
REQ-015 Command and response channels SHALL operate concurrently and independently except through FIFO occupancy.

Reset
REQ-016 On reset_n=0, asynchronously: FIFO empty, pointers 0, lock=0, beat counter 0, last-winner=m1 (m0 priority). Hence all *_wrdy_o, *_rval_o, s_cmd_wval_o and s_res_rrdy_o SHALL be 0 (wrdy/rrdy via the empty/blocked gating); data outputs follow their combinational sources.
REQ-017 Reset mid-burst SHALL discard lock and outstanding entries; the first cycle after release behaves as REQ-006 with m0 priority.

Verification
REQ-018 Both masters hold single-beat reads, s_cmd_wrdy_i=1 -> grants alternate m0,m1,m0,m1; FIFO shows 0,1,0,1.
REQ-019 m0 write bl=4 accepted while m1 requests -> s_cmd carries 4 consecutive m0 beats; m1 granted on cycle 5.
REQ-020 Issue OD=4 reads with no response -> 5th first beat sees wrdy=0; one lack response pops, 5th accepted next cycle.
REQ-021 m0 read bl=3 then m1 read bl=1; slave returns 3 beats (lack on 3rd) then 1 -> beats 1-3 on m0 only, 4th on m1; m0_res_rrdy_i=0 stalls s_res_rrdy_o.
REQ-022 s_res_rval_i=1 with empty FIFO -> s_res_rrdy_o=0, no m<i>_res_rval_o.
REQ-023 reset_n low during locked burst at counter=2 -> lock cleared, FIFO empty, next grant m0.

Source files
------------

// File: rtl/wbi_cmd_arb.sv
// Two-master command arbiter with write-burst locking and an in-order
// response router driven by a FIFO of granted master ids.
module wbi_cmd_arb #(
   parameter int unsigned AW = 32,
   parameter int unsigned BW = 4,
   parameter int unsigned BL = 10,
   parameter int unsigned DW = 32,
   parameter int unsigned OD = 4
) (
   input  logic          mclk,
   input  logic          reset_n,
   // master 0
   input  logic          m0_cmd_wval_i,
   output logic          m0_cmd_wrdy_o,
   input  logic [AW-1:0] m0_cmd_adr_i,
   input  logic          m0_cmd_we_i,
   input  logic [DW-1:0] m0_cmd_dat_i,
   input  logic [BW-1:0] m0_cmd_sel_i,
   input  logic [3:0]    m0_cmd_tid_i,
   input  logic [BL-1:0] m0_cmd_bl_i,
   input  logic          m0_res_rrdy_i,
   output logic          m0_res_rval_o,
   output logic [DW-1:0] m0_res_dat_o,
   output logic          m0_res_ack_o,
   output logic          m0_res_lack_o,
   output logic          m0_res_err_o,
   output logic [3:0]    m0_res_tid_o,
   // master 1
   input  logic          m1_cmd_wval_i,
   output logic          m1_cmd_wrdy_o,
   input  logic [AW-1:0] m1_cmd_adr_i,
   input  logic          m1_cmd_we_i,
   input  logic [DW-1:0] m1_cmd_dat_i,
   input  logic [BW-1:0] m1_cmd_sel_i,
   input  logic [3:0]    m1_cmd_tid_i,
   input  logic [BL-1:0] m1_cmd_bl_i,
   input  logic          m1_res_rrdy_i,
   output logic          m1_res_rval_o,
   output logic [DW-1:0] m1_res_dat_o,
   output logic          m1_res_ack_o,
   output logic          m1_res_lack_o,
   output logic          m1_res_err_o,
   output logic [3:0]    m1_res_tid_o,
   // shared slave side
   output logic          s_cmd_wval_o,
   input  logic          s_cmd_wrdy_i,
   output logic [AW-1:0] s_cmd_adr_o,
   output logic          s_cmd_we_o,
   output logic [DW-1:0] s_cmd_dat_o,
   output logic [BW-1:0] s_cmd_sel_o,
   output logic [3:0]    s_cmd_tid_o,
   output logic [BL-1:0] s_cmd_bl_o,
   input  logic          s_res_rval_i,
   output logic          s_res_rrdy_o,
   input  logic [DW-1:0] s_res_dat_i,
   input  logic          s_res_ack_i,
   input  logic          s_res_lack_i,
   input  logic          s_res_err_i,
   input  logic [3:0]    s_res_tid_i
);

   localparam int unsigned PW = (OD > 1) ? $clog2(OD) : 1;
   localparam int unsigned CW = $clog2(OD + 1);

   typedef enum logic {ARB, BURST} state_t;

   state_t        state;
   logic          last;      // 1: m1 won the most recent first beat
   logic [BL-1:0] beat_cnt;
   logic          fifo_q [OD];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic full, empty, blk, gnt, head;
   logic cmd_xfer, push, pop, burst;

   assign full  = (count == CW'(OD));
   assign empty = (count == '0);
   // Only first beats are held back by a full FIFO; reset forces all ready low.
   assign blk   = ~reset_n | (full & (state == ARB));
   assign head  = fifo_q[rd_ptr];

   always_comb begin
      gnt = ~last;
      if (state == BURST)
         gnt = last;
      else if (m0_cmd_wval_i && !m1_cmd_wval_i)
         gnt = 1'b0;
      else if (m1_cmd_wval_i && !m0_cmd_wval_i)
         gnt = 1'b1;
   end

   always_comb begin
      if (gnt) begin
         s_cmd_wval_o = m1_cmd_wval_i & ~blk;
         s_cmd_adr_o  = m1_cmd_adr_i;
         s_cmd_we_o   = m1_cmd_we_i;
         s_cmd_dat_o  = m1_cmd_dat_i;
         s_cmd_sel_o  = m1_cmd_sel_i;
         s_cmd_tid_o  = m1_cmd_tid_i;
         s_cmd_bl_o   = m1_cmd_bl_i;
      end else begin
         s_cmd_wval_o = m0_cmd_wval_i & ~blk;
         s_cmd_adr_o  = m0_cmd_adr_i;
         s_cmd_we_o   = m0_cmd_we_i;
         s_cmd_dat_o  = m0_cmd_dat_i;
         s_cmd_sel_o  = m0_cmd_sel_i;
         s_cmd_tid_o  = m0_cmd_tid_i;
         s_cmd_bl_o   = m0_cmd_bl_i;
      end
   end

   assign m0_cmd_wrdy_o = ~gnt & s_cmd_wrdy_i & ~blk;
   assign m1_cmd_wrdy_o =  gnt & s_cmd_wrdy_i & ~blk;

   assign cmd_xfer = s_cmd_wval_o & s_cmd_wrdy_i;
   assign push     = cmd_xfer & (state == ARB);
   assign burst    = s_cmd_we_o & (s_cmd_bl_o > BL'(1));

   assign m0_res_rval_o = s_res_rval_i & ~empty & ~head;
   assign m1_res_rval_o = s_res_rval_i & ~empty &  head;
   assign s_res_rrdy_o  = ~empty & (head ? m1_res_rrdy_i : m0_res_rrdy_i);
   assign pop           = s_res_rval_i & s_res_rrdy_o & s_res_lack_i;

   assign m0_res_dat_o  = s_res_dat_i;
   assign m0_res_ack_o  = s_res_ack_i;
   assign m0_res_lack_o = s_res_lack_i;
   assign m0_res_err_o  = s_res_err_i;
   assign m0_res_tid_o  = s_res_tid_i;
   assign m1_res_dat_o  = s_res_dat_i;
   assign m1_res_ack_o  = s_res_ack_i;
   assign m1_res_lack_o = s_res_lack_i;
   assign m1_res_err_o  = s_res_err_i;
   assign m1_res_tid_o  = s_res_tid_i;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ARB;
         last     <= 1'b1;
         beat_cnt <= '0;
      end else if (cmd_xfer) begin
         case (state)
            ARB: begin
               last <= gnt;
               if (burst) begin
                  state    <= BURST;
                  beat_cnt <= s_cmd_bl_o - BL'(1);
               end
            end
            BURST: begin
               beat_cnt <= beat_cnt - BL'(1);
               if (beat_cnt == BL'(1))
                  state <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < OD; i++)
            fifo_q[i] <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= gnt;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_wbi_cmd_arb.sv
// Directed bench for wbi_cmd_arb: expected command addresses and response
// owners are queued as stimulus is driven and checked as the DUT transfers.
module tb_wbi_cmd_arb;

   logic        mclk = 1'b0;
   logic        reset_n;
   logic        m0_wval, m0_wrdy, m0_we, m0_rrdy, m0_rval, m0_ack, m0_lack, m0_err;
   logic [31:0] m0_adr, m0_dat, m0_rdat;
   logic [3:0]  m0_sel, m0_tid, m0_rtid;
   logic [9:0]  m0_bl;
   logic        m1_wval, m1_wrdy, m1_we, m1_rrdy, m1_rval, m1_ack, m1_lack, m1_err;
   logic [31:0] m1_adr, m1_dat, m1_rdat;
   logic [3:0]  m1_sel, m1_tid, m1_rtid;
   logic [9:0]  m1_bl;
   logic        s_wval, s_wrdy, s_we, s_rval, s_rrdy, s_ack, s_lack, s_err;
   logic [31:0] s_adr, s_dat, s_rdat;
   logic [3:0]  s_sel, s_tid, s_rtid;
   logic [9:0]  s_bl;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_cmd[$];
   logic        exp_res[$];

   always #5 mclk = ~mclk;

   wbi_cmd_arb #(.AW(32), .BW(4), .BL(10), .DW(32), .OD(4)) dut (
      .mclk(mclk), .reset_n(reset_n),
      .m0_cmd_wval_i(m0_wval), .m0_cmd_wrdy_o(m0_wrdy), .m0_cmd_adr_i(m0_adr),
      .m0_cmd_we_i(m0_we), .m0_cmd_dat_i(m0_dat), .m0_cmd_sel_i(m0_sel),
      .m0_cmd_tid_i(m0_tid), .m0_cmd_bl_i(m0_bl), .m0_res_rrdy_i(m0_rrdy),
      .m0_res_rval_o(m0_rval), .m0_res_dat_o(m0_rdat), .m0_res_ack_o(m0_ack),
      .m0_res_lack_o(m0_lack), .m0_res_err_o(m0_err), .m0_res_tid_o(m0_rtid),
      .m1_cmd_wval_i(m1_wval), .m1_cmd_wrdy_o(m1_wrdy), .m1_cmd_adr_i(m1_adr),
      .m1_cmd_we_i(m1_we), .m1_cmd_dat_i(m1_dat), .m1_cmd_sel_i(m1_sel),
      .m1_cmd_tid_i(m1_tid), .m1_cmd_bl_i(m1_bl), .m1_res_rrdy_i(m1_rrdy),
      .m1_res_rval_o(m1_rval), .m1_res_dat_o(m1_rdat), .m1_res_ack_o(m1_ack),
      .m1_res_lack_o(m1_lack), .m1_res_err_o(m1_err), .m1_res_tid_o(m1_rtid),
      .s_cmd_wval_o(s_wval), .s_cmd_wrdy_i(s_wrdy), .s_cmd_adr_o(s_adr),
      .s_cmd_we_o(s_we), .s_cmd_dat_o(s_dat), .s_cmd_sel_o(s_sel),
      .s_cmd_tid_o(s_tid), .s_cmd_bl_o(s_bl),
      .s_res_rval_i(s_rval), .s_res_rrdy_o(s_rrdy), .s_res_dat_i(s_rdat),
      .s_res_ack_i(s_ack), .s_res_lack_i(s_lack), .s_res_err_i(s_err),
      .s_res_tid_i(s_rtid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at negedge when a command transfer is expected this cycle.
   task automatic cmd_chk(input string tag);
      logic [31:0] a;
      chk({tag, "_wval"}, {31'd0, s_wval & s_wrdy}, 32'd1);
      if (exp_cmd.size() == 0) begin
         chk({tag, "_cmdq_empty"}, 32'd0, 32'd1);
      end else begin
         a = exp_cmd.pop_front();
         chk({tag, "_adr"}, s_adr, a);
         chk({tag, "_wrdy0"}, {31'd0, m0_wrdy}, {31'd0, a[31:8] == 24'h1 || a[31:8] == 24'h3});
         chk({tag, "_wrdy1"}, {31'd0, m1_wrdy}, {31'd0, a[31:8] == 24'h2});
      end
   endtask

   // Called at negedge while a response beat is presented and forwarded.
   task automatic res_chk(input string tag);
      logic h;
      if (exp_res.size() == 0) begin
         chk({tag, "_resq_empty"}, 32'd0, 32'd1);
      end else begin
         h = exp_res[0];
         chk({tag, "_rval0"}, {31'd0, m0_rval}, {31'd0, ~h});
         chk({tag, "_rval1"}, {31'd0, m1_rval}, {31'd0, h});
         chk({tag, "_rrdy"}, {31'd0, s_rrdy}, 32'd1);
         chk({tag, "_dat"}, h ? m1_rdat : m0_rdat, s_rdat);
         if (s_lack) void'(exp_res.pop_front());
      end
   endtask

   task automatic next;
      @(posedge mclk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      {m0_wval, m0_we, m1_wval, m1_we} = '0;
      m0_adr = 32'h100; m1_adr = 32'h200;
      m0_dat = 32'hD0; m1_dat = 32'hD1; m0_sel = 4'hF; m1_sel = 4'hF;
      m0_tid = 4'h3; m1_tid = 4'h9; m0_bl = 10'd1; m1_bl = 10'd1;
      m0_rrdy = 1'b1; m1_rrdy = 1'b1;
      s_wrdy = 1'b1; s_rval = 1'b1; s_lack = 1'b1; s_ack = 1'b1; s_err = 1'b0;
      s_rdat = 32'hAAAA_0000; s_rtid = 4'h5;
      m0_wval = 1'b1;

      // reset state
      @(negedge mclk);
      chk("rst_m0_wrdy", {31'd0, m0_wrdy}, 32'd0);
      chk("rst_s_wval", {31'd0, s_wval}, 32'd0);
      chk("rst_s_rrdy", {31'd0, s_rrdy}, 32'd0);
      chk("rst_rval", {30'd0, m0_rval, m1_rval}, 32'd0);
      next();
      reset_n = 1'b1;
      m0_wval = 1'b0; s_rval = 1'b0;

      // alternating single-beat reads fill the order FIFO 0,1,0,1
      m0_wval = 1'b1; m1_wval = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_cmd.push_back(i[0] ? 32'h200 : 32'h100);
         exp_res.push_back(i[0]);
         @(negedge mclk);
         cmd_chk("rr");
         next();
      end

      // full: first beats blocked; one lack response frees a slot
      s_rval = 1'b1; s_lack = 1'b1; s_rdat = 32'hAAAA_0001;
      @(negedge mclk);
      chk("full_s_wval", {31'd0, s_wval}, 32'd0);
      chk("full_wrdy", {30'd0, m0_wrdy, m1_wrdy}, 32'd0);
      res_chk("pop1");
      next();
      s_rval = 1'b0;
      exp_cmd.push_back(32'h100);
      exp_res.push_back(1'b0);
      @(negedge mclk);
      cmd_chk("fifth");
      next();
      m0_wval = 1'b0; m1_wval = 1'b0;

      // drain in order 1,0,1,0
      s_rval = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_rdat = 32'hBB00_0000 + i;
         @(negedge mclk);
         res_chk("drain");
         next();
      end
      s_rval = 1'b0;

      // m0 read bl=3, then m1 read bl=1
      m0_wval = 1'b1; m0_bl = 10'd3;
      exp_cmd.push_back(32'h100); exp_res.push_back(1'b0);
      @(negedge mclk);
      cmd_chk("rd3");
      next();
      m0_wval = 1'b0; m1_wval = 1'b1;
      exp_cmd.push_back(32'h200); exp_res.push_back(1'b1);
      @(negedge mclk);
      cmd_chk("rd1");
      next();
      m1_wval = 1'b0;

      // head master not ready stalls the slave
      s_rval = 1'b1; s_lack = 1'b0; m0_rrdy = 1'b0;
      @(negedge mclk);
      chk("stall_rrdy", {31'd0, s_rrdy}, 32'd0);
      chk("stall_rval0", {31'd0, m0_rval}, 32'd1);
      chk("stall_rval1", {31'd0, m1_rval}, 32'd0);
      next();
      m0_rrdy = 1'b1;
      for (int b = 0; b < 4; b++) begin
         s_lack = (b >= 2);
         s_rdat = 32'hCC00_0000 + b;
         @(negedge mclk);
         res_chk("beat");
         next();
      end

      // empty FIFO: slave response is not accepted
      s_lack = 1'b1;
      @(negedge mclk);
      chk("empty_rrdy", {31'd0, s_rrdy}, 32'd0);
      chk("empty_rval", {30'd0, m0_rval, m1_rval}, 32'd0);
      next();
      s_rval = 1'b0;

      // m0 write burst bl=4 holds the grant against m1
      m0_wval = 1'b1; m0_we = 1'b1; m0_bl = 10'd4; m0_adr = 32'h100;
      m1_wval = 1'b1; m1_bl = 10'd1;
      exp_res.push_back(1'b0); exp_res.push_back(1'b1);
      for (int k = 0; k < 4; k++) begin
         exp_cmd.push_back(32'h100 + 4 * k);
         @(negedge mclk);
         if (k == 0) begin
            chk("bst_we", {31'd0, s_we}, 32'd1);
            chk("bst_bl", {22'd0, s_bl}, 32'd4);
         end
         cmd_chk("bst");
         next();
         m0_adr = m0_adr + 32'd4;
      end
      m0_wval = 1'b0;
      exp_cmd.push_back(32'h200);
      @(negedge mclk);
      cmd_chk("after_bst");
      next();
      m1_wval = 1'b0;

      // reset during a burst at counter 2
      m0_wval = 1'b1; m0_adr = 32'h300;
      for (int k = 0; k < 2; k++) begin
         exp_cmd.push_back(32'h300 + 4 * k);
         @(negedge mclk);
         cmd_chk("pre_rst");
         next();
         m0_adr = m0_adr + 32'd4;
      end
      #2 reset_n = 1'b0;
      @(negedge mclk);
      chk("midrst_wrdy", {30'd0, m0_wrdy, m1_wrdy}, 32'd0);
      chk("midrst_wval", {31'd0, s_wval}, 32'd0);
      next();
      reset_n = 1'b1;
      exp_res.delete();
      m0_we = 1'b0; m0_bl = 10'd1; m0_adr = 32'h100; m1_wval = 1'b1;
      s_rval = 1'b1; s_lack = 1'b1;
      exp_cmd.push_back(32'h100);
      @(negedge mclk);
      chk("postrst_rrdy", {31'd0, s_rrdy}, 32'd0);
      chk("postrst_rval", {30'd0, m0_rval, m1_rval}, 32'd0);
      cmd_chk("postrst_m0");
      next();
      s_rval = 1'b0;
      exp_cmd.push_back(32'h200);
      @(negedge mclk);
      cmd_chk("postrst_m1");
      next();
      m0_wval = 1'b0; m1_wval = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
